// File: rtl/antirrebote_boton.sv
// ============================================================================
//  Module   : antirrebote_boton
//  Purpose  : Push-button debouncer with two-flop synchronizer, validation
//             flag and optional one-shot long-press pulse (enabled by the
//             macro ANTIRREBOTE_PULSO_LARGO_EN; default build omits it).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module antirrebote_boton #(
  parameter int CICLOS_ESTABLE = 500000,
  parameter int CICLOS_LARGO   = 50000000,
  parameter int ANCHO_CONTADOR = 26
) (
  input  logic clock,
  input  logic resetN,
  input  logic botonSucio,
  output logic botonLimpio,
  output logic enValidacion,
  output logic pulsacionLarga
);

  typedef enum logic [1:0] {
    REPOSO         = 2'd0,
    VALIDANDO_ALTO = 2'd1,
    PULSADO        = 2'd2,
    VALIDANDO_BAJO = 2'd3
  } estado_t;

  localparam logic [ANCHO_CONTADOR-1:0] c_cero       = '0;
  localparam logic [ANCHO_CONTADOR-1:0] c_uno        = ANCHO_CONTADOR'(1);
  localparam logic [ANCHO_CONTADOR-1:0] c_fin_estable = ANCHO_CONTADOR'(CICLOS_ESTABLE - 1);

  // Reject parameter sets where the shared counter could wrap.
  if (!(CICLOS_ESTABLE >= 2 && CICLOS_ESTABLE < CICLOS_LARGO &&
        longint'(CICLOS_LARGO) < (longint'(1) << ANCHO_CONTADOR))) begin : g_param_invalido
    $error("antirrebote_boton: invalid CICLOS_ESTABLE/CICLOS_LARGO/ANCHO_CONTADOR");
  end

`ifdef ANTIRREBOTE_PULSO_LARGO_EN
  localparam logic [ANCHO_CONTADOR-1:0] c_fin_largo = ANCHO_CONTADOR'(CICLOS_LARGO - 1);
  localparam logic [ANCHO_CONTADOR-1:0] c_saturado  = ANCHO_CONTADOR'(CICLOS_LARGO);
`endif

  logic                      r_s1;
  logic                      r_s2;
  estado_t                   r_estado;
  logic [ANCHO_CONTADOR-1:0] r_contador;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_estado     <= REPOSO;
      r_contador   <= c_cero;
      botonLimpio  <= 1'b0;
      enValidacion <= 1'b0;
`ifdef ANTIRREBOTE_PULSO_LARGO_EN
      pulsacionLarga <= 1'b0;
`endif
    end else begin
      r_s1 <= botonSucio;
      r_s2 <= r_s1;
`ifdef ANTIRREBOTE_PULSO_LARGO_EN
      pulsacionLarga <= 1'b0;
`endif
      case (r_estado)
        REPOSO: begin
          if (r_s2) begin
            r_estado     <= VALIDANDO_ALTO;
            r_contador   <= c_uno;
            enValidacion <= 1'b1;
          end
        end
        VALIDANDO_ALTO: begin
          if (!r_s2) begin
            r_estado     <= REPOSO;
            r_contador   <= c_cero;
            enValidacion <= 1'b0;
          end else if (r_contador == c_fin_estable) begin
            r_estado     <= PULSADO;
            r_contador   <= c_cero;
            botonLimpio  <= 1'b1;
            enValidacion <= 1'b0;
          end else begin
            r_contador <= r_contador + c_uno;
          end
        end
        PULSADO: begin
          if (!r_s2) begin
            r_estado     <= VALIDANDO_BAJO;
            r_contador   <= c_uno;
            enValidacion <= 1'b1;
          end else begin
`ifdef ANTIRREBOTE_PULSO_LARGO_EN
            // Parking at CICLOS_LARGO keeps the pulse one-shot while held.
            if (r_contador < c_fin_largo) begin
              r_contador <= r_contador + c_uno;
            end else if (r_contador == c_fin_largo) begin
              r_contador     <= c_saturado;
              pulsacionLarga <= 1'b1;
            end
`endif
          end
        end
        VALIDANDO_BAJO: begin
          if (r_s2) begin
            r_estado     <= PULSADO;
            r_contador   <= c_cero;
            enValidacion <= 1'b0;
          end else if (r_contador == c_fin_estable) begin
            r_estado     <= REPOSO;
            r_contador   <= c_cero;
            botonLimpio  <= 1'b0;
            enValidacion <= 1'b0;
          end else begin
            r_contador <= r_contador + c_uno;
          end
        end
        default: begin
          r_estado     <= REPOSO;
          r_contador   <= c_cero;
          botonLimpio  <= 1'b0;
          enValidacion <= 1'b0;
        end
      endcase
    end
  end

`ifndef ANTIRREBOTE_PULSO_LARGO_EN
  assign pulsacionLarga = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/antirrebote_boton.md
ANTIRREBOTE_BOTON -- requirements
Module: antirrebote_boton

Interface
REQ-001 SHALL have parameter CICLOS_ESTABLE, default 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz).
REQ-002 SHALL have parameter CICLOS_LARGO, default 50000000, cycles of held press before long-press pulse (1 s at 50 MHz).
REQ-003 SHALL have parameter ANCHO_CONTADOR, default 26, shared counter width.
REQ-004 SHALL have port clock  input  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port resetN  input  1  synchronous, active-low reset.
REQ-006 SHALL have port botonSucio  input  1  raw asynchronous push-button level, bouncing.
REQ-007 SHALL have port botonLimpio  output  1  registered debounced level; feeds the edge-to-impulse stage.
REQ-008 SHALL have port enValidacion  output  1  registered; high while a level change is being validated.
REQ-009 SHALL have port pulsacionLarga  output  1  registered one-cycle long-press pulse.

Function
REQ-010 SHALL pass botonSucio through a two-flop synchronizer (s1, s2); the FSM SHALL use only s2.
REQ-011 SHALL implement FSM states REPOSO, VALIDANDO_ALTO, PULSADO, VALIDANDO_BAJO.
REQ-012 SHALL, in REPOSO: s2=1 -> VALIDANDO_ALTO, counter=1; else stay.
REQ-013 SHALL, in VALIDANDO_ALTO: s2=0 -> REPOSO, counter=0; counter==CICLOS_ESTABLE-1 -> PULSADO, botonLimpio=1, counter=0; else counter+1.
REQ-014 SHALL, in PULSADO: s2=0 -> VALIDANDO_BAJO, counter=1; else long-press counting per REQ-019.
REQ-015 SHALL, in VALIDANDO_BAJO: s2=1 -> PULSADO, counter=0; counter==CICLOS_ESTABLE-1 -> REPOSO, botonLimpio=0, counter=0; else counter+1.
REQ-016 SHALL change botonLimpio exactly 2+CICLOS_ESTABLE rising edges after the first edge sampling the new raw level, when that level is held; any opposite sample restarts validation from zero.
REQ-017 SHALL drive enValidacion=1 exactly while in VALIDANDO_ALTO or VALIDANDO_BAJO (registered with the state).
REQ-018 SHALL hold botonLimpio constant for any glitch shorter than CICLOS_ESTABLE cycles (after synchronization).
REQ-019 SHALL, in PULSADO with s2=1, increment the counter and assert pulsacionLarga for one cycle when counter reaches CICLOS_LARGO-1, then saturate (no further pulse) until the state is left.
REQ-020 SHALL restart long-press counting from 0 on every re-entry to PULSADO, including after an aborted VALIDANDO_BAJO.
REQ-021 SHALL never let the counter wrap; parameters SHALL satisfy 2 <= CICLOS_ESTABLE < CICLOS_LARGO < 2^ANCHO_CONTADOR.

Reset
REQ-022 SHALL, on a rising edge with resetN=0, set s1, s2, counter to 0, state REPOSO, botonLimpio, enValidacion, pulsacionLarga to 0.
REQ-023 SHALL apply reset mid-press: botonLimpio drops to 0 at that edge; if raw stays high, it re-rises 2+CICLOS_ESTABLE edges after the first edge with resetN=1.
REQ-024 SHALL give resetN priority over every other input.

Configuration
REQ-025 SHALL, with macro ANTIRREBOTE_PULSO_LARGO_EN defined, implement REQ-019/REQ-020.
REQ-026 SHALL, without ANTIRREBOTE_PULSO_LARGO_EN, omit long-press logic, tie pulsacionLarga to constant 0, and keep the port list unchanged; debounce behaviour identical.

Verification (CICLOS_ESTABLE=4, CICLOS_LARGO=10, ANCHO_CONTADOR=8)
REQ-027 SHALL cover: raw 0->1 before edge 1, held -> enValidacion high after edges 3-5, botonLimpio=1 after edge 6.
REQ-028 SHALL cover: raw high edges 1-3, low edge 4, high from edge 5 held -> botonLimpio 0 through glitch, rises after edge 10.
REQ-029 SHALL cover: stable press then raw 1->0 held -> botonLimpio falls 6 edges later; a 1-cycle high during release keeps botonLimpio=1 and restarts the 6-edge count.
REQ-030 SHALL cover (macro defined): press accepted at edge 6, held -> pulsacionLarga high for exactly one cycle after edge 16, never again while held.
REQ-031 SHALL cover: resetN=0 for one edge while botonLimpio=1 and raw held high -> all outputs 0 at that edge, botonLimpio re-rises 6 edges after reset release.
REQ-032 SHALL cover (macro undefined): 40-cycle press -> pulsacionLarga stays 0; botonLimpio timing as REQ-027.
